// File: rtl/MIPS_pkg.sv
// MIPS memory geometry and boot-loader state/phase encodings.
package MIPS_pkg;

    localparam int unsigned MIPS_MEMORY_ADDR_WIDTH = 8;
    localparam int unsigned MIPS_DATA_WIDTH        = 32;
    localparam int unsigned BOOT_HDR_BYTES         = 2;

    typedef enum logic [3:0] {
        IDLE,
        POLL,
        POLL_WAIT,
        GAP,
        READ,
        READ_WAIT,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } boot_state_t;

    typedef enum logic [1:0] {
        PH_HEADER,
        PH_PAYLOAD,
        PH_CHECKSUM
    } load_phase_t;

endpackage

// File: rtl/UART_csr_pkg.sv
// UART control/status register map as seen by the boot loader.
package UART_csr_pkg;

    typedef logic [3:0] uart_csr_addr_t;
    typedef logic [7:0] uart_csr_data_t;

    localparam uart_csr_addr_t UART_CSR_STATUS_ADDR  = 4'h4;
    localparam uart_csr_addr_t UART_CSR_RX_DATA_ADDR = 4'h8;
    localparam int unsigned    UART_RX_VALID_BIT     = 0;

endpackage

// File: rtl/uart_boot_loader.sv
// Polls the UART for a word-count/payload/checksum stream, writes the payload
// into MIPS memory, then releases the core (DONE) or holds it in reset (ERROR).
module uart_boot_loader
    import UART_csr_pkg::*;
    import MIPS_pkg::*;
#(
    parameter int unsigned POLL_GAP = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output uart_csr_addr_t                    csr_rd_addr,
    output logic                              csr_ren,
    input  uart_csr_data_t                    csr_rd_data,
    output logic [MIPS_MEMORY_ADDR_WIDTH-1:0] mem_addr,
    output logic [MIPS_DATA_WIDTH-1:0]        mem_wr_data,
    output logic                              mem_wr_en,
    output logic                              mem_chip_sel,
    output logic                              bus_owner,
    output logic                              mips_rst_n,
    output logic                              boot_done,
    output logic                              boot_error
);

    localparam int unsigned AW        = MIPS_MEMORY_ADDR_WIDTH;
    localparam int unsigned DW        = MIPS_DATA_WIDTH;
    localparam int unsigned GAP_W     = $clog2(POLL_GAP + 2);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** AW);

    boot_state_t       state, state_nxt;
    load_phase_t       phase;
    logic [1:0]        byte_cnt;
    logic [AW:0]       word_idx;
    logic [15:0]       word_cnt;
    logic [DW-1:0]     asm_word;
    logic [7:0]        csum;
    logic [7:0]        rx_byte;
    logic [GAP_W-1:0]  gap_cnt;

    logic [7:0]        rx_b;
    logic [15:0]       hdr_n;
    logic              hdr_last;
    logic              last_word;

    assign rx_b      = csr_rd_data;
    assign hdr_n     = {rx_b, word_cnt[7:0]};
    assign hdr_last  = (byte_cnt == 2'(BOOT_HDR_BYTES - 1));
    assign last_word = ((16'(word_idx) + 16'd1) == word_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // GAP lasts POLL_GAP+1 cycles, so status strobes recur every POLL_GAP+3 cycles.
    always_comb begin
        state_nxt    = state;
        csr_ren      = 1'b0;
        csr_rd_addr  = '0;
        mem_wr_en    = 1'b0;
        mem_chip_sel = 1'b0;
        mem_addr     = '0;
        mem_wr_data  = '0;
        bus_owner    = 1'b1;
        mips_rst_n   = 1'b0;
        boot_done    = 1'b0;
        boot_error   = 1'b0;
        case (state)
            IDLE:      state_nxt = POLL;
            POLL: begin
                csr_ren     = 1'b1;
                csr_rd_addr = UART_CSR_STATUS_ADDR;
                state_nxt   = POLL_WAIT;
            end
            POLL_WAIT: state_nxt = csr_rd_data[UART_RX_VALID_BIT] ? READ : GAP;
            GAP:       state_nxt = (gap_cnt == GAP_W'(POLL_GAP)) ? POLL : GAP;
            READ: begin
                csr_ren     = 1'b1;
                csr_rd_addr = UART_CSR_RX_DATA_ADDR;
                state_nxt   = READ_WAIT;
            end
            READ_WAIT: begin
                case (phase)
                    PH_HEADER:  state_nxt = (hdr_last && ({1'b0, hdr_n} > MAX_WORDS)) ? ERROR : POLL;
                    PH_PAYLOAD: state_nxt = (byte_cnt == 2'd3) ? WRITE : POLL;
                    default:    state_nxt = CHECK;
                endcase
            end
            WRITE: begin
                mem_wr_en    = 1'b1;
                mem_chip_sel = 1'b1;
                mem_addr     = word_idx[AW-1:0];
                mem_wr_data  = asm_word;
                state_nxt    = POLL;
            end
            CHECK:     state_nxt = (rx_byte == csum) ? DONE : ERROR;
            DONE: begin
                bus_owner  = 1'b0;
                mips_rst_n = 1'b1;
                boot_done  = 1'b1;
            end
            ERROR:     boot_error = 1'b1;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= PH_HEADER;
            byte_cnt <= '0;
            word_idx <= '0;
            word_cnt <= '0;
            asm_word <= '0;
            csum     <= '0;
            rx_byte  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                POLL_WAIT: gap_cnt <= '0;
                GAP:       gap_cnt <= gap_cnt + GAP_W'(1);
                READ_WAIT: begin
                    case (phase)
                        PH_HEADER: begin
                            csum <= csum ^ rx_b;
                            if (!hdr_last) begin
                                word_cnt[7:0] <= rx_b;
                                byte_cnt      <= byte_cnt + 2'd1;
                            end else begin
                                word_cnt <= hdr_n;
                                byte_cnt <= '0;
                                phase    <= (hdr_n == '0) ? PH_CHECKSUM : PH_PAYLOAD;
                            end
                        end
                        PH_PAYLOAD: begin
                            csum                             <= csum ^ rx_b;
                            asm_word[{byte_cnt, 3'b000} +: 8] <= rx_b;
                            byte_cnt                         <= byte_cnt + 2'd1;
                        end
                        default: rx_byte <= rx_b;
                    endcase
                end
                WRITE: begin
                    word_idx <= word_idx + (AW + 1)'(1);
                    if (last_word) phase <= PH_CHECKSUM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized stream-level bench for uart_boot_loader with a UART RX FIFO model.
module tb_uart_boot_loader;
    import UART_csr_pkg::*;
    import MIPS_pkg::*;

    localparam int unsigned POLL_GAP = 4;
    localparam int unsigned AW       = MIPS_MEMORY_ADDR_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n;
    uart_csr_addr_t       csr_rd_addr;
    logic                 csr_ren;
    uart_csr_data_t       csr_rd_data = '0;
    logic [AW-1:0]        mem_addr;
    logic [31:0]          mem_wr_data;
    logic                 mem_wr_en;
    logic                 mem_chip_sel;
    logic                 bus_owner;
    logic                 mips_rst_n;
    logic                 boot_done;
    logic                 boot_error;

    uart_boot_loader #(.POLL_GAP(POLL_GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_rd_addr  (csr_rd_addr),
        .csr_ren      (csr_ren),
        .csr_rd_data  (csr_rd_data),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_chip_sel (mem_chip_sel),
        .bus_owner    (bus_owner),
        .mips_rst_n   (mips_rst_n),
        .boot_done    (boot_done),
        .boot_error   (boot_error)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // UART RX FIFO: bench pushes into fifo_mem, the CSR model pops.
    byte unsigned fifo_mem [0:4095];
    int unsigned  push_cnt = 0;
    int unsigned  pop_cnt  = 0;
    int unsigned  cyc      = 0;

    int unsigned  wr_addr_q[$];
    logic [31:0]  wr_data_q[$];
    int unsigned  poll_cyc_q[$];
    int unsigned  data_reads = 0;
    int unsigned  viol       = 0;

    function automatic logic [7:0] make_status(input bit valid);
        logic [7:0] t;
        t = 8'($urandom);
        t[UART_RX_VALID_BIT] = valid;
        return t;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            pop_cnt <= push_cnt;
        end else if (csr_ren) begin
            if (csr_rd_addr == UART_CSR_STATUS_ADDR) begin
                csr_rd_data <= make_status(pop_cnt < push_cnt);
            end else if (csr_rd_addr == UART_CSR_RX_DATA_ADDR && pop_cnt < push_cnt) begin
                csr_rd_data <= fifo_mem[pop_cnt[11:0]];
                pop_cnt     <= pop_cnt + 1;
            end else begin
                csr_rd_data <= 8'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wr_data);
        end
        if (csr_ren && csr_rd_addr == UART_CSR_STATUS_ADDR)  poll_cyc_q.push_back(cyc);
        if (csr_ren && csr_rd_addr == UART_CSR_RX_DATA_ADDR) data_reads++;
        if (csr_ren && mem_wr_en) viol++;
        if (!bus_owner && (csr_ren || mem_wr_en || mem_chip_sel)) viol++;
        if (mips_rst_n == bus_owner) viol++;
        if (mem_wr_en != mem_chip_sel) viol++;
    end

    // Reference stream: LE count, LE words, XOR checksum (optionally corrupted).
    function automatic void build_stream(input int unsigned n, input logic [31:0] words[$],
                                         input logic [7:0] csum_flip, output byte unsigned s[$]);
        logic [7:0] x;
        s = {};
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        foreach (words[i])
            for (int b = 0; b < 4; b++) s.push_back(8'(words[i] >> (8 * b)));
        x = '0;
        foreach (s[i]) x ^= s[i];
        s.push_back(x ^ csum_flip);
    endfunction

    task automatic feed(input byte unsigned s[$], input int unsigned max_gap);
        foreach (s[i]) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            fifo_mem[push_cnt[11:0]] = s[i];
            push_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_end(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (boot_done || boot_error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [50:0] got, exp;
        exp = 51'b1000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {csr_ren, csr_rd_addr, mem_wr_en, mem_chip_sel, mem_addr, mem_wr_data,
               bus_owner, mips_rst_n, boot_done, boot_error};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_values: got %h, expected %h", got, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (csr_ren !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: csr_ren got %b, expected 0", csr_ren);
        end
        @(posedge clk);
        #1;
        checks++;
        if (csr_ren !== 1'b1 || csr_rd_addr !== UART_CSR_STATUS_ADDR) begin
            errors++;
            $display("FAIL first_poll: ren %b addr %h, expected 1 / %h", csr_ren, csr_rd_addr, UART_CSR_STATUS_ADDR);
        end
        @(posedge clk);
        #1;
        checks++;
        if (csr_ren !== 1'b0) begin
            errors++;
            $display("FAIL poll_single_cycle: csr_ren got %b, expected 0", csr_ren);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {csr_ren, csr_rd_addr, mem_wr_en, mem_chip_sel, mem_addr, mem_wr_data,
               bus_owner, mips_rst_n, boot_done, boot_error};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_reset: got %h, expected %h", got, exp);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal_load();
        logic [31:0]  words[$];
        byte unsigned s[$];
        int unsigned  w0, v0;
        bit           ok;
        words = {32'h11223344, 32'hA5A5A5A5};
        do_reset();
        w0 = wr_addr_q.size();
        v0 = viol;
        build_stream(2, words, 8'h00, s);
        feed(s, 5);
        wait_end(3000, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL normal_timeout: no done/error within budget");
        end
        checks++;
        if (wr_addr_q.size() - w0 !== 2) begin
            errors++;
            $display("FAIL normal_write_count: got %0d, expected 2", wr_addr_q.size() - w0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wr_addr_q[w0 + i] !== i || wr_data_q[w0 + i] !== words[i]) begin
                    errors++;
                    $display("FAIL normal_write%0d: got %0d/%h, expected %0d/%h", i,
                             wr_addr_q[w0 + i], wr_data_q[w0 + i], i, words[i]);
                end
            end
        end
        checks++;
        if ({boot_done, boot_error, mips_rst_n, bus_owner} !== 4'b1010) begin
            errors++;
            $display("FAIL normal_status: done/err/rst_n/owner got %b, expected 1010",
                     {boot_done, boot_error, mips_rst_n, bus_owner});
        end
        checks++;
        if (viol - v0 !== 0) begin
            errors++;
            $display("FAIL normal_protocol: violations got %0d, expected 0", viol - v0);
        end
    endtask

    task automatic test_empty_load();
        logic [31:0]  words[$];
        byte unsigned s[$];
        int unsigned  w0;
        bit           ok;
        words = {};
        do_reset();
        w0 = wr_addr_q.size();
        build_stream(0, words, 8'h00, s);
        feed(s, 3);
        wait_end(1000, ok);
        checks++;
        if (!ok || boot_done !== 1'b1 || boot_error !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: ok %b done %b err %b, expected 1 1 0", ok, boot_done, boot_error);
        end
        checks++;
        if (wr_addr_q.size() - w0 !== 0) begin
            errors++;
            $display("FAIL empty_writes: got %0d, expected 0", wr_addr_q.size() - w0);
        end
    endtask

    task automatic test_bad_checksum();
        logic [31:0]  words[$];
        byte unsigned s[$];
        int unsigned  w0;
        bit           ok;
        words = {32'hDEADBEEF};
        do_reset();
        w0 = wr_addr_q.size();
        build_stream(1, words, 8'h01, s);
        feed(s, 4);
        wait_end(2000, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (wr_addr_q.size() - w0 !== 1) begin
            errors++;
            $display("FAIL badsum_write_count: got %0d, expected 1", wr_addr_q.size() - w0);
        end else begin
            checks++;
            if (wr_addr_q[w0] !== 0 || wr_data_q[w0] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL badsum_write: got %0d/%h, expected 0/deadbeef", wr_addr_q[w0], wr_data_q[w0]);
            end
        end
        checks++;
        if (!ok || {boot_done, boot_error, mips_rst_n, bus_owner} !== 4'b0101) begin
            errors++;
            $display("FAIL badsum_status: ok %b done/err/rst_n/owner %b, expected 0101",
                     ok, {boot_done, boot_error, mips_rst_n, bus_owner});
        end
    endtask

    task automatic test_oversize_header();
        logic [31:0]  words[$];
        byte unsigned s[$];
        int unsigned  w0, r0, p0;
        bit           ok;
        words = {};
        do_reset();
        w0 = wr_addr_q.size();
        r0 = data_reads;
        build_stream((2 ** AW) + 1, words, 8'h00, s);
        s.delete(2);
        s.push_back(8'h12); s.push_back(8'h34); s.push_back(8'h56); s.push_back(8'h78);
        p0 = push_cnt;
        feed(s, 2);
        wait_end(1000, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || boot_error !== 1'b1 || boot_done !== 1'b0) begin
            errors++;
            $display("FAIL oversize_error: ok %b err %b done %b, expected 1 1 0", ok, boot_error, boot_done);
        end
        checks++;
        if (data_reads - r0 !== 2 || wr_addr_q.size() - w0 !== 0) begin
            errors++;
            $display("FAIL oversize_reads: reads %0d writes %0d, expected 2 0",
                     data_reads - r0, wr_addr_q.size() - w0);
        end
        checks++;
        if (push_cnt - pop_cnt !== 4 || push_cnt - p0 !== 6) begin
            errors++;
            $display("FAIL oversize_unread: left %0d, expected 4", push_cnt - pop_cnt);
        end
    endtask

    task automatic test_max_words();
        logic [31:0]  words[$];
        byte unsigned s[$];
        int unsigned  w0, bad;
        bit           ok;
        words = {};
        for (int i = 0; i < 2 ** AW; i++) words.push_back($urandom);
        do_reset();
        w0 = wr_addr_q.size();
        build_stream(2 ** AW, words, 8'h00, s);
        feed(s, 0);
        wait_end(12000, ok);
        checks++;
        if (!ok || boot_done !== 1'b1) begin
            errors++;
            $display("FAIL max_done: ok %b done %b, expected 1 1", ok, boot_done);
        end
        checks++;
        if (wr_addr_q.size() - w0 !== 2 ** AW) begin
            errors++;
            $display("FAIL max_write_count: got %0d, expected %0d", wr_addr_q.size() - w0, 2 ** AW);
        end else begin
            bad = 0;
            for (int i = 0; i < 2 ** AW; i++)
                if (wr_addr_q[w0 + i] !== i || wr_data_q[w0 + i] !== words[i]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL max_write_contents: %0d wrong words, expected 0", bad);
            end
        end
    endtask

    task automatic test_poll_gap();
        int unsigned p0, r0, n;
        do_reset();
        p0 = poll_cyc_q.size();
        r0 = data_reads;
        repeat (50) @(negedge clk);
        n = poll_cyc_q.size() - p0;
        checks++;
        if (n < 6 || n > 8) begin
            errors++;
            $display("FAIL poll_count: got %0d, expected 7", n);
        end
        for (int unsigned i = p0 + 1; i < poll_cyc_q.size(); i++) begin
            checks++;
            if (poll_cyc_q[i] - poll_cyc_q[i - 1] !== POLL_GAP + 3) begin
                errors++;
                $display("FAIL poll_period: got %0d, expected %0d", poll_cyc_q[i] - poll_cyc_q[i - 1], POLL_GAP + 3);
            end
        end
        checks++;
        if (data_reads - r0 !== 0) begin
            errors++;
            $display("FAIL poll_no_reads: got %0d, expected 0", data_reads - r0);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0]  words[$];
        byte unsigned s[$];
        int unsigned  w0;
        bit           ok, drained;
        words = {32'hCAFEF00D};
        do_reset();
        w0 = wr_addr_q.size();
        build_stream(1, words, 8'h00, s);
        s = s[0:4];
        feed(s, 3);
        drained = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (pop_cnt == push_cnt) begin
                drained = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (!drained || wr_addr_q.size() - w0 !== 0) begin
            errors++;
            $display("FAIL midload_partial: drained %b writes %0d, expected 1 0", drained, wr_addr_q.size() - w0);
        end
        words = {$urandom};
        do_reset();
        build_stream(1, words, 8'h00, s);
        feed(s, 4);
        wait_end(2000, ok);
        checks++;
        if (!ok || boot_done !== 1'b1) begin
            errors++;
            $display("FAIL midload_done: ok %b done %b, expected 1 1", ok, boot_done);
        end
        checks++;
        if (wr_addr_q.size() - w0 !== 1) begin
            errors++;
            $display("FAIL midload_write_count: got %0d, expected 1", wr_addr_q.size() - w0);
        end else begin
            checks++;
            if (wr_addr_q[w0] !== 0 || wr_data_q[w0] !== words[0]) begin
                errors++;
                $display("FAIL midload_write: got %0d/%h, expected 0/%h", wr_addr_q[w0], wr_data_q[w0], words[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0]  words[$];
        byte unsigned s[$];
        logic [7:0]   flip;
        int unsigned  n, w0, v0, bad;
        bit           ok;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(6, 1);
            words = {};
            for (int unsigned i = 0; i < n; i++) words.push_back($urandom);
            flip = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
            do_reset();
            w0 = wr_addr_q.size();
            v0 = viol;
            build_stream(n, words, flip, s);
            feed(s, 6);
            wait_end(4000, ok);
            checks++;
            if (!ok || boot_done !== (flip == 0) || boot_error !== (flip != 0)) begin
                errors++;
                $display("FAIL random%0d_status: ok %b done %b err %b, expected 1 %b %b",
                         t, ok, boot_done, boot_error, flip == 0, flip != 0);
            end
            checks++;
            if (wr_addr_q.size() - w0 !== n) begin
                errors++;
                $display("FAIL random%0d_write_count: got %0d, expected %0d", t, wr_addr_q.size() - w0, n);
            end else begin
                bad = 0;
                for (int unsigned i = 0; i < n; i++)
                    if (wr_addr_q[w0 + i] !== i || wr_data_q[w0 + i] !== words[i]) bad++;
                checks++;
                if (bad !== 0) begin
                    errors++;
                    $display("FAIL random%0d_contents: %0d wrong words, expected 0", t, bad);
                end
            end
            checks++;
            if (viol - v0 !== 0) begin
                errors++;
                $display("FAIL random%0d_protocol: violations %0d, expected 0", t, viol - v0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_normal_load();
        test_empty_load();
        test_bad_checksum();
        test_oversize_header();
        test_max_words();
        test_poll_gap();
        test_reset_mid_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
